// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared encodings for the ALU sequencer (class codes, opcodes, field positions, FSM states)
package alu_seq_pkg;

    localparam int INSTR_W = 16;

    // Instruction field bit positions
    localparam int CLS_HI = 15;
    localparam int CLS_LO = 14;
    localparam int OP_HI  = 13;
    localparam int OP_LO  = 11;
    localparam int RD_HI  = 10;
    localparam int RD_LO  = 8;
    localparam int RA_HI  = 7;
    localparam int RA_LO  = 5;
    localparam int RB_HI  = 4;
    localparam int RB_LO  = 2;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        CLS_ALU = 2'b00,
        CLS_LDI = 2'b01,
        CLS_NOP = 2'b10,
        CLS_ILL = 2'b11
    } cls_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_SHL = 3'd6,
        OP_SHR = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Only add/sub produce a meaningful carry/borrow; all other ops keep flag_c.
    function automatic logic op_updates_carry(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// rtl/alu_seq_regfile.sv - 8-entry register file, two read ports, debug read port, one write port
module alu_seq_regfile #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        raddr_a_i,
    input  logic [2:0]        raddr_b_i,
    input  logic [2:0]        raddr_dbg_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o,
    output logic [DATA_W-1:0] rdata_dbg_o,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [8];

    assign rdata_a_o   = mem_q[raddr_a_i];
    assign rdata_b_o   = mem_q[raddr_b_i];
    assign rdata_dbg_o = mem_q[raddr_dbg_i];

    // Clear all entries on reset; otherwise a single synchronous write per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - instruction sequencer driving an external 8-bit ALU; optional retire counter via ALU_SEQ_RETIRE_CNT_EN
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_carry,
    output logic              done,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_c,
    input  logic [2:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    output logic [CNT_W-1:0]  retired_cnt
);

    state_e               state_q;
    logic [15:0]          instr_q;
    logic [DATA_W-1:0]    result_q;
    logic                 zero_q;
    logic                 carry_q;
    logic                 done_q;
    logic                 illegal_q;
    logic                 flag_z_q;
    logic                 flag_c_q;

    logic [1:0]           cls;
    logic [2:0]           op;
    logic [2:0]           rd;
    logic [2:0]           ra;
    logic [2:0]           rb;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    rdata_a;
    logic [DATA_W-1:0]    rdata_b;
    logic                 wb_we;
    logic [DATA_W-1:0]    wb_data;
    logic                 unused_instr_bits;

    assign cls = instr_q[CLS_HI:CLS_LO];
    assign op  = instr_q[OP_HI:OP_LO];
    assign rd  = instr_q[RD_HI:RD_LO];
    assign ra  = instr_q[RA_HI:RA_LO];
    assign rb  = instr_q[RB_HI:RB_LO];
    assign imm = instr_q[IMM_HI:IMM_LO];
    assign unused_instr_bits = ^instr_q[1:0];

    // Register writes commit at the WB edge; reset inside the regfile wins over this.
    assign wb_we   = (state_q == ST_WB) && ((cls == CLS_ALU) || (cls == CLS_LDI));
    assign wb_data = (cls == CLS_LDI) ? imm : result_q;

    alu_seq_regfile #(
        .DATA_W (DATA_W)
    ) u_regfile (
        .clk         (clk),
        .rst         (rst),
        .raddr_a_i   (ra),
        .raddr_b_i   (rb),
        .raddr_dbg_i (dbg_sel),
        .rdata_a_o   (rdata_a),
        .rdata_b_o   (rdata_b),
        .rdata_dbg_o (dbg_data),
        .we_i        (wb_we),
        .waddr_i     (rd),
        .wdata_i     (wb_data)
    );

    // Operands are presented to the ALU only during EXEC of an ALU-class word.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = 3'd0;
        if ((state_q == ST_EXEC) && (cls == CLS_ALU)) begin
            alu_a  = rdata_a;
            alu_b  = rdata_b;
            alu_op = op;
        end
    end

    // Sequencer FSM: accept, execute (capture ALU result), write back and retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            flag_z_q  <= 1'b0;
            flag_c_q  <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        instr_q <= in_instr;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_out;
                    zero_q   <= alu_zero;
                    carry_q  <= alu_carry;
                    state_q  <= ST_WB;
                end
                ST_WB: begin
                    done_q    <= 1'b1;
                    illegal_q <= (cls == CLS_ILL);
                    if (cls == CLS_ALU) begin
                        flag_z_q <= zero_q;
                        if (op_updates_carry(op)) begin
                            flag_c_q <= carry_q;
                        end
                    end
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == ST_IDLE);
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign flag_z   = flag_z_q;
    assign flag_c   = flag_c_q;

`ifdef ALU_SEQ_RETIRE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Count legal retirements at the commit edge, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if ((state_q == ST_WB) && (cls != CLS_ILL) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign retired_cnt = cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_out;
    logic        alu_zero;
    logic        alu_carry;
    logic        done;
    logic        illegal;
    logic        flag_z;
    logic        flag_c;
    logic [2:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [15:0] retired_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    alu_sequencer #(.DATA_W(8), .CNT_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .done        (done),
        .illegal     (illegal),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU
    always_comb begin
        logic [8:0] t;
        t = 9'd0;
        case (alu_op)
            3'd0: t = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1: t = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2: t = {1'b0, alu_a & alu_b};
            3'd3: t = {1'b0, alu_a | alu_b};
            3'd4: t = {1'b0, alu_a ^ alu_b};
            3'd5: t = {1'b0, ~alu_a};
            3'd6: t = {alu_a[7], alu_a[6:0], 1'b0};
            default: t = {alu_a[0], 1'b0, alu_a[7:1]};
        endcase
        alu_out   = t[7:0];
        alu_carry = t[8];
        alu_zero  = (t[7:0] == 8'd0);
    end

    function automatic logic [15:0] enc_alu(input logic [2:0] op, input logic [2:0] rd,
                                            input logic [2:0] ra, input logic [2:0] rb);
        return {2'b00, op, rd, ra, rb, 2'b00};
    endfunction

    function automatic logic [15:0] enc_ldi(input logic [2:0] rd, input logic [7:0] imm);
        return {2'b01, 3'b000, rd, imm};
    endfunction

    function automatic logic [15:0] cnt_expected();
`ifdef ALU_SEQ_RETIRE_CNT_EN
        return exp_cnt[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input logic [2:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        chk($sformatf("reg r%0d", idx), {24'd0, dbg_data}, {24'd0, exp});
    endtask

    // Issue one word from IDLE and check the EXEC operands and done timing.
    task automatic run(input logic [15:0] w, input logic exp_ill,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [2:0] eop);
        @(negedge clk);
        chk("ready_before", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_instr = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        @(negedge clk);
        chk("exec_done", {31'd0, done}, 32'd0);
        chk("exec_ready", {31'd0, in_ready}, 32'd0);
        chk("exec_alu_a", {24'd0, alu_a}, {24'd0, ea});
        chk("exec_alu_b", {24'd0, alu_b}, {24'd0, eb});
        chk("exec_alu_op", {29'd0, alu_op}, {29'd0, eop});
        @(negedge clk);
        chk("wb_done", {31'd0, done}, 32'd0);
        chk("wb_alu_a", {24'd0, alu_a}, 32'd0);
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("done_illegal", {31'd0, illegal}, {31'd0, exp_ill});
        chk("done_ready", {31'd0, in_ready}, 32'd1);
        if (!exp_ill) exp_cnt++;
    endtask

    initial begin
        logic [15:0] words [4];
        int acc_cyc [4];
        int acc;
        int cyc;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_sel  = 3'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_flag_z", {31'd0, flag_z}, 32'd0);
        chk("rst_flag_c", {31'd0, flag_c}, 32'd0);
        chk("rst_alu", {16'd0, alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
        chk("rst_cnt", {16'd0, retired_cnt}, 32'd0);
        for (int i = 0; i < 8; i++) chk_reg(i[2:0], 8'h00);

        // 0x7F + 0x01 = 0x80, no carry
        run(enc_ldi(3'd1, 8'h7F), 1'b0, 8'h00, 8'h00, 3'd0);
        run(enc_ldi(3'd2, 8'h01), 1'b0, 8'h00, 8'h00, 3'd0);
        run(enc_alu(3'd0, 3'd3, 3'd1, 3'd2), 1'b0, 8'h7F, 8'h01, 3'd0);
        chk_reg(3'd3, 8'h80);
        chk("add1_z", {31'd0, flag_z}, 32'd0);
        chk("add1_c", {31'd0, flag_c}, 32'd0);

        // 0xFF + 0x01 = 0x00 with carry; AND keeps C
        run(enc_ldi(3'd1, 8'hFF), 1'b0, 8'h00, 8'h00, 3'd0);
        run(enc_alu(3'd0, 3'd3, 3'd1, 3'd2), 1'b0, 8'hFF, 8'h01, 3'd0);
        chk_reg(3'd3, 8'h00);
        chk("add2_z", {31'd0, flag_z}, 32'd1);
        chk("add2_c", {31'd0, flag_c}, 32'd1);
        run(enc_alu(3'd2, 3'd4, 3'd1, 3'd2), 1'b0, 8'hFF, 8'h01, 3'd2);
        chk_reg(3'd4, 8'h01);
        chk("and_z", {31'd0, flag_z}, 32'd0);
        chk("and_c_held", {31'd0, flag_c}, 32'd1);

        // 0x01 - 0x02 = 0xFF with borrow; SHL of 0xFF gives 0xFE
        run(enc_ldi(3'd1, 8'h02), 1'b0, 8'h00, 8'h00, 3'd0);
        run(enc_alu(3'd1, 3'd0, 3'd2, 3'd1), 1'b0, 8'h01, 8'h02, 3'd1);
        chk_reg(3'd0, 8'hFF);
        chk("sub_z", {31'd0, flag_z}, 32'd0);
        chk("sub_c", {31'd0, flag_c}, 32'd1);
        run(enc_alu(3'd6, 3'd5, 3'd0, 3'd0), 1'b0, 8'hFF, 8'hFF, 3'd6);
        chk_reg(3'd5, 8'hFE);
        chk("shl_c_held", {31'd0, flag_c}, 32'd1);

        // Streaming: in_valid held high, poison word presented while busy
        words[0] = enc_ldi(3'd6, 8'h10);
        words[1] = enc_ldi(3'd7, 8'h20);
        words[2] = enc_alu(3'd0, 3'd6, 3'd6, 3'd7);
        words[3] = enc_alu(3'd4, 3'd7, 3'd6, 3'd7);
        acc = 0;
        cyc = 0;
        while (acc < 4 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            in_valid = 1'b1;
            if (in_ready) begin
                in_instr = words[acc];
                acc_cyc[acc] = cyc;
                acc++;
            end else begin
                in_instr = enc_ldi(3'd7, 8'hEE);
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        chk("stream_accepts", acc, 4);
        for (int i = 1; i < 4; i++) chk("stream_gap", acc_cyc[i] - acc_cyc[i-1], 3);
        repeat (3) @(negedge clk);
        chk("stream_last_done", {31'd0, done}, 32'd1);
        exp_cnt += 4;
        chk_reg(3'd6, 8'h30);
        chk_reg(3'd7, 8'h10);
        chk("stream_z", {31'd0, flag_z}, 32'd0);
        chk("stream_c", {31'd0, flag_c}, 32'd0);
        chk("stream_cnt", {16'd0, retired_cnt}, {16'd0, cnt_expected()});

        // Illegal then NOP: no state change, illegal only on the first
        run(16'hC000, 1'b1, 8'h00, 8'h00, 3'd0);
        run(16'h8000, 1'b0, 8'h00, 8'h00, 3'd0);
        chk_reg(3'd0, 8'hFF);
        chk_reg(3'd1, 8'h02);
        chk_reg(3'd2, 8'h01);
        chk_reg(3'd3, 8'h00);
        chk_reg(3'd4, 8'h01);
        chk_reg(3'd5, 8'hFE);
        chk_reg(3'd6, 8'h30);
        chk_reg(3'd7, 8'h10);
        chk("ill_z", {31'd0, flag_z}, 32'd0);
        chk("ill_c", {31'd0, flag_c}, 32'd0);
        chk("ill_cnt", {16'd0, retired_cnt}, {16'd0, cnt_expected()});

        // Reset during EXEC of ADD r3 discards it
        run(enc_ldi(3'd3, 8'h55), 1'b0, 8'h00, 8'h00, 3'd0);
        chk_reg(3'd3, 8'h55);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = enc_alu(3'd0, 3'd3, 3'd1, 3'd2);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_in_exec", {31'd0, in_ready}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_done0", {31'd0, done}, 32'd0);
        chk("rstmid_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("rstmid_done1", {31'd0, done}, 32'd0);
        @(negedge clk);
        chk("rstmid_done2", {31'd0, done}, 32'd0);
        chk_reg(3'd3, 8'h00);
        chk("rstmid_z", {31'd0, flag_z}, 32'd0);
        chk("rstmid_c", {31'd0, flag_c}, 32'd0);
        chk("rstmid_cnt", {16'd0, retired_cnt}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
